// File: rtl/controller_ram_lanes.sv
// Byte-lane RAM with req/ack handshake, read latency 1+PIPE and an optional post-reset clear sweep.
// Define CTRL_RAM_WPROT_EN to add the wp/err write protection of addresses below WP_TOP.
module controller_ram_lanes #(
  parameter int unsigned ADDR_WIDTH     = 15,
  parameter int unsigned BYTES          = 4,
  parameter int unsigned PIPE           = 0,
  parameter int unsigned CLEAR_ON_RESET = 1,
`ifdef CTRL_RAM_WPROT_EN
  parameter int unsigned WP_TOP         = 2 ** (ADDR_WIDTH - 1),
`endif
  parameter logic [7:0]  CLEAR_VALUE    = 8'h00
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  we,
  input  logic [BYTES-1:0]      bytesel,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [8*BYTES-1:0]    d,
`ifdef CTRL_RAM_WPROT_EN
  input  logic                  wp,
  output logic                  err,
`endif
  output logic                  busy,
  output logic                  ack,
  output logic [8*BYTES-1:0]    q
);

  localparam int unsigned DW    = 8 * BYTES;
  localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  typedef enum logic {ST_CLEAR, ST_READY} state_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] cnt, cnt_nxt;
  logic                  sweep_we_c;
  logic                  accept_c, wr_c, rd_c, prot_c;

  // Sweep sequencing: one word per cycle from address 0 up to the last word.
  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sweep_we_c = 1'b0;
    case (state)
      ST_CLEAR: begin
        sweep_we_c = 1'b1;
        cnt_nxt    = cnt + ADDR_WIDTH'(1);
        if (cnt == LAST_ADDR) state_nxt = ST_READY;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      cnt   <= '0;
      busy  <= 1'b1;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= (state_nxt == ST_CLEAR);
    end
  end

  assign accept_c = req && !busy && !reset;
`ifdef CTRL_RAM_WPROT_EN
  assign prot_c   = wp && (32'(addr) < WP_TOP);
`else
  assign prot_c   = 1'b0;
`endif
  assign wr_c     = accept_c && we && !prot_c;
  assign rd_c     = accept_c && !we;

  logic [DW-1:0] mem [DEPTH];

  // bytesel[k] owns the k-th byte counted from the most significant end.
  always_ff @(posedge clk) begin
    if (!reset && sweep_we_c) begin
      mem[cnt] <= {BYTES{CLEAR_VALUE}};
    end else if (wr_c) begin
      for (int unsigned k = 0; k < BYTES; k++) begin
        if (bytesel[k]) mem[addr][8*(BYTES-1-k) +: 8] <= d[8*(BYTES-1-k) +: 8];
      end
    end
  end

  // First stage: read-first array access plus per-request bookkeeping.
  logic          v1, r1;
  logic [DW-1:0] rd1;

  always_ff @(posedge clk) begin
    if (reset) begin
      v1  <= 1'b0;
      r1  <= 1'b0;
      rd1 <= '0;
    end else begin
      v1 <= accept_c;
      r1 <= rd_c;
      if (rd_c) rd1 <= mem[addr];
    end
  end

`ifdef CTRL_RAM_WPROT_EN
  logic e1, eo;
  always_ff @(posedge clk) begin
    if (reset) e1 <= 1'b0;
    else       e1 <= accept_c && we && prot_c;
  end
`endif

  logic          vo, ro;
  logic [DW-1:0] rdo;

  if (PIPE != 0) begin : g_pipe
    logic          v2, r2;
    logic [DW-1:0] rd2;
    always_ff @(posedge clk) begin
      if (reset) begin
        v2  <= 1'b0;
        r2  <= 1'b0;
        rd2 <= '0;
      end else begin
        v2  <= v1;
        r2  <= r1;
        rd2 <= rd1;
      end
    end
    assign vo  = v2;
    assign ro  = r2;
    assign rdo = rd2;
`ifdef CTRL_RAM_WPROT_EN
    logic e2;
    always_ff @(posedge clk) begin
      if (reset) e2 <= 1'b0;
      else       e2 <= e1;
    end
    assign eo = e2;
`endif
  end else begin : g_nopipe
    assign vo  = v1;
    assign ro  = r1;
    assign rdo = rd1;
`ifdef CTRL_RAM_WPROT_EN
    assign eo  = e1;
`endif
  end

  // Response stage: q only moves on read acks.
  always_ff @(posedge clk) begin
    if (reset) begin
      ack <= 1'b0;
      q   <= '0;
    end else begin
      ack <= vo;
      if (vo && ro) q <= rdo;
    end
  end

`ifdef CTRL_RAM_WPROT_EN
  always_ff @(posedge clk) begin
    if (reset) err <= 1'b0;
    else       err <= vo && eo;
  end
`endif

endmodule

// File: tb/tb_controller_ram_lanes.sv
// Drives a PIPE=0 and a PIPE=1 instance with shared stimulus; checks both against a
// request/response scoreboard model plus directed tables for the latency corners.
module tb_controller_ram_lanes;

  localparam int unsigned AW  = 4;
  localparam int unsigned NW  = 16;
  localparam logic [31:0] CLR = 32'hA5A5A5A5;

  logic        clk = 1'b0;
  logic        reset = 1'b1, req = 1'b0, we = 1'b0;
  logic [3:0]  bytesel = '0;
  logic [3:0]  addr = '0;
  logic [31:0] d = '0;
  logic        busy0, busy1, ack0, ack1;
  logic [31:0] q0, q1;
`ifdef CTRL_RAM_WPROT_EN
  logic        wp = 1'b0;
  logic        err0, err1;
`endif

  always #5 clk = ~clk;

  controller_ram_lanes #(
    .ADDR_WIDTH(AW), .BYTES(4), .PIPE(0), .CLEAR_ON_RESET(1),
`ifdef CTRL_RAM_WPROT_EN
    .WP_TOP(8),
`endif
    .CLEAR_VALUE(8'hA5)
  ) dut0 (
    .clk(clk), .reset(reset), .req(req), .we(we), .bytesel(bytesel), .addr(addr), .d(d),
`ifdef CTRL_RAM_WPROT_EN
    .wp(wp), .err(err0),
`endif
    .busy(busy0), .ack(ack0), .q(q0)
  );

  controller_ram_lanes #(
    .ADDR_WIDTH(AW), .BYTES(4), .PIPE(1), .CLEAR_ON_RESET(1),
`ifdef CTRL_RAM_WPROT_EN
    .WP_TOP(8),
`endif
    .CLEAR_VALUE(8'hA5)
  ) dut1 (
    .clk(clk), .reset(reset), .req(req), .we(we), .bytesel(bytesel), .addr(addr), .d(d),
`ifdef CTRL_RAM_WPROT_EN
    .wp(wp), .err(err1),
`endif
    .busy(busy1), .ack(ack1), .q(q1)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: memory image, sweep progress and a log of accepted requests by edge.
  logic [31:0] m_mem [NW];
  bit          m_busy = 1'b1;
  bit          sweeping = 1'b0;
  int          sw_idx = 0;
  int          edge_no = 0;
  int          last_rst = -1;
  bit          acc_v  [0:4095];
  bit          acc_rd [0:4095];
  bit          acc_er [0:4095];
  logic [31:0] acc_dat[0:4095];
  bit          mack [2];
  bit          merr [2];
  logic [31:0] mq   [2];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit acc, prot;
    int n;
    edge_no++;
    acc_v[edge_no] = 1'b0;
    if (reset) begin
      last_rst = edge_no;
      sweeping = 1'b1;
      sw_idx   = 0;
      m_busy   = 1'b1;
      for (int l = 0; l < 2; l++) begin
        mq[l] = '0; mack[l] = 1'b0; merr[l] = 1'b0;
      end
    end else begin
      acc = req && !m_busy;
`ifdef CTRL_RAM_WPROT_EN
      prot = wp && (addr < 4'd8);
`else
      prot = 1'b0;
`endif
      acc_v[edge_no]  = acc;
      acc_rd[edge_no] = acc && !we;
      acc_er[edge_no] = acc && we && prot;
      if (sweeping) begin
        m_mem[sw_idx] = CLR;
        sw_idx++;
        if (sw_idx == NW) sweeping = 1'b0;
      end
      if (acc) begin
        acc_dat[edge_no] = m_mem[addr];
        if (we && !prot)
          for (int k = 0; k < 4; k++)
            if (bytesel[k]) m_mem[addr][8*(3-k) +: 8] = d[8*(3-k) +: 8];
      end
      m_busy = sweeping;
      for (int l = 0; l < 2; l++) begin
        n = edge_no - (l + 1);
        mack[l] = 1'b0;
        merr[l] = 1'b0;
        if (n > last_rst && acc_v[n]) begin
          mack[l] = 1'b1;
          merr[l] = acc_er[n];
          if (acc_rd[n]) mq[l] = acc_dat[n];
        end
      end
    end
  endtask

  // One clock: model steps on the edge, outputs are compared on the falling edge.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("busy0", 32'(busy0), 32'(m_busy));
    chk("busy1", 32'(busy1), 32'(m_busy));
    chk("ack0",  32'(ack0),  32'(mack[0]));
    chk("ack1",  32'(ack1),  32'(mack[1]));
    chk("q0",    q0,         mq[0]);
    chk("q1",    q1,         mq[1]);
`ifdef CTRL_RAM_WPROT_EN
    chk("err0",  32'(err0),  32'(merr[0]));
    chk("err1",  32'(err1),  32'(merr[1]));
`endif
  endtask

  task automatic idle();
    req = 1'b0; we = 1'b0; bytesel = '0;
  endtask

  task automatic do_read(input logic [3:0] a, input logic [31:0] exp, input string nm);
    req = 1'b1; we = 1'b0; addr = a; bytesel = '0;
    step();
    idle();
    step();
    chk({nm, "_ack_p0"}, 32'(ack0), 32'd1);
    chk({nm, "_q_p0"}, q0, exp);
    step();
    chk({nm, "_ack_p1"}, 32'(ack1), 32'd1);
    chk({nm, "_q_p1"}, q1, exp);
  endtask

  task automatic sweep_len(input string nm);
    int n = 0;
    reset = 1'b0;
    while (busy0 === 1'b1 && n < 100) begin
      req = (n == 12);
      we = 1'b1; addr = 4'd2; d = 32'h0; bytesel = 4'hF;
      n++;
      step();
    end
    idle();
    chk(nm, 32'(n), 32'd16);
  endtask

  typedef struct {
    logic        req, we;
    logic [3:0]  bs, a;
    logic [31:0] d;
    logic        ack0;
    logic [31:0] q0;
    logic        ack1;
    logic [31:0] q1;
  } vec_t;

  vec_t tbl[14];

  function automatic vec_t mk(input logic r, input logic w, input logic [3:0] bs,
                              input logic [3:0] a, input logic [31:0] dd,
                              input logic k0, input logic [31:0] v0,
                              input logic k1, input logic [31:0] v1);
    vec_t v;
    v.req = r; v.we = w; v.bs = bs; v.a = a; v.d = dd;
    v.ack0 = k0; v.q0 = v0; v.ack1 = k1; v.q1 = v1;
    return v;
  endfunction

  initial begin
    // Expected outputs after each edge; both q registers start the table at CLR.
    // 4'b0101 enables lanes 0 and 2, i.e. d[31:24] and d[15:8].
    tbl[0]  = mk(1, 1, 4'b0101, 4'd3, 32'h11223344, 0, CLR,          0, CLR);
    tbl[1]  = mk(1, 0, 4'b0000, 4'd3, 32'h0,        1, CLR,          0, CLR);
    tbl[2]  = mk(1, 1, 4'b1111, 4'd5, 32'hDEADBEEF, 1, 32'h11A533A5, 1, CLR);
    tbl[3]  = mk(1, 0, 4'b0000, 4'd5, 32'h0,        1, 32'h11A533A5, 1, 32'h11A533A5);
    tbl[4]  = mk(1, 0, 4'b0000, 4'd6, 32'h0,        1, 32'hDEADBEEF, 1, 32'h11A533A5);
    tbl[5]  = mk(1, 0, 4'b0000, 4'd7, 32'h0,        1, CLR,          1, 32'hDEADBEEF);
    tbl[6]  = mk(1, 1, 4'b1111, 4'd7, 32'h01020304, 1, CLR,          1, CLR);
    tbl[7]  = mk(1, 0, 4'b0000, 4'd7, 32'h0,        1, CLR,          1, CLR);
    tbl[8]  = mk(0, 0, 4'b0000, 4'd0, 32'h0,        1, 32'h01020304, 1, CLR);
    tbl[9]  = mk(0, 0, 4'b0000, 4'd0, 32'h0,        0, 32'h01020304, 1, 32'h01020304);
    tbl[10] = mk(1, 1, 4'b0000, 4'd8, 32'hFFFFFFFF, 0, 32'h01020304, 0, 32'h01020304);
    tbl[11] = mk(1, 0, 4'b0000, 4'd8, 32'h0,        1, 32'h01020304, 0, 32'h01020304);
    tbl[12] = mk(0, 0, 4'b0000, 4'd0, 32'h0,        1, CLR,          1, 32'h01020304);
    tbl[13] = mk(0, 0, 4'b0000, 4'd0, 32'h0,        0, CLR,          1, CLR);

    // Reset state and full sweep length.
    reset = 1'b1;
    step();
    step();
    chk("rst_busy", 32'(busy0), 32'd1);
    chk("rst_ack",  32'(ack0 | ack1), 32'd0);
    chk("rst_q",    q0 | q1, 32'd0);
    sweep_len("sweep_len");
    for (int i = 0; i < NW; i++) do_read(4'(i), CLR, "clear_rd");

    // Reset in the middle of a sweep; a write attempted while busy must vanish.
    reset = 1'b1;
    step();
    reset = 1'b0;
    for (int i = 0; i < 9; i++) step();
    reset = 1'b1;
    step();
    sweep_len("resweep_len");
    do_read(4'd2, CLR, "busy_wr_blocked");

    for (int i = 0; i < 14; i++) begin
      req = tbl[i].req; we = tbl[i].we; bytesel = tbl[i].bs; addr = tbl[i].a; d = tbl[i].d;
      step();
      chk($sformatf("tbl%0d_ack_p0", i), 32'(ack0), 32'(tbl[i].ack0));
      chk($sformatf("tbl%0d_q_p0", i),   q0,        tbl[i].q0);
      chk($sformatf("tbl%0d_ack_p1", i), 32'(ack1), 32'(tbl[i].ack1));
      chk($sformatf("tbl%0d_q_p1", i),   q1,        tbl[i].q1);
    end
    idle();

`ifdef CTRL_RAM_WPROT_EN
    wp = 1'b1;
    req = 1'b1; we = 1'b1; addr = 4'd2; d = 32'hFFFFFFFF; bytesel = 4'hF;
    step();
    idle();
    step();
    chk("wp_lo_ack", 32'(ack0), 32'd1);
    chk("wp_lo_err", 32'(err0), 32'd1);
    step();
    chk("wp_lo_err_p1", 32'(err1), 32'd1);
    do_read(4'd2, CLR, "wp_lo_kept");
    req = 1'b1; we = 1'b1; addr = 4'd9; d = 32'hFFFFFFFF; bytesel = 4'hF;
    step();
    idle();
    step();
    chk("wp_hi_ack", 32'(ack0), 32'd1);
    chk("wp_hi_err", 32'(err0), 32'd0);
    step();
    do_read(4'd9, 32'hFFFFFFFF, "wp_hi_stored");
    wp = 1'b0;
`endif

    // Random traffic with occasional resets, checked against the model every cycle.
    for (int i = 0; i < 800; i++) begin
      reset   = ($urandom_range(0, 149) == 0);
      req     = ($urandom_range(0, 3) != 0);
      we      = 1'($urandom_range(0, 1));
      addr    = 4'($urandom_range(0, NW - 1));
      d       = $urandom;
      bytesel = 4'($urandom_range(0, 15));
`ifdef CTRL_RAM_WPROT_EN
      wp      = 1'($urandom_range(0, 1));
`endif
      step();
    end
    reset = 1'b0;
    idle();
    for (int i = 0; i < 20; i++) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
